// File: rtl/des_iter_core.sv
// Iterative DES datapath: IP at start, one Feistel round per clock for 16 clocks, IP^-1 at the end.
// Subkeys come from an external scheduler, which answers key_idx_o combinationally on subkey_i.
module des_iter_core (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic        decrypt_i,
    input  logic [0:63] data_in_i,
    input  logic [0:47] subkey_i,
    output logic [3:0]  key_idx_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [0:63] data_out_o
);
    // Tables use FIPS 46-3 1-based positions; bit 0 of every [0:N] vector is FIPS position 1.
    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};
    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};
    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
    localparam int SBOX_T [512] = '{
        14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
        0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
        4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
        15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13,
        15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
        3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
        0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
        13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9,
        10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
        13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
        13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
        1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12,
        7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
        13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
        10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
        3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14,
        2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
        14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
        4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
        11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3,
        12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
        10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
        9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
        4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13,
        4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
        13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
        1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
        6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12,
        13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
        1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
        7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
        2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11};

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  roundCnt_q, roundCnt_d;
    logic [0:31] left_q, left_d;
    logic [0:31] right_q, right_d;
    logic        decrypt_q, decrypt_d;
    logic [0:63] dataOut_q, dataOut_d;
    logic        done_q, done_d;
    logic [0:63] ipOut;
    logic [0:31] fOut;

    function automatic logic [0:63] initPerm(input logic [0:63] x);
        logic [0:63] y;
        for (int i = 0; i < 64; i++) y[i] = x[IP_T[i] - 1];
        return y;
    endfunction

    function automatic logic [0:63] finalPerm(input logic [0:63] x);
        logic [0:63] y;
        for (int i = 0; i < 64; i++) y[i] = x[FP_T[i] - 1];
        return y;
    endfunction

    // S-box ROM address is {box, outer bits (row), inner four bits (column)}.
    function automatic logic [0:31] feistel(input logic [0:31] r, input logic [0:47] k);
        logic [0:47] x;
        logic [0:31] s;
        logic [0:31] p;
        logic [0:5]  six;
        for (int i = 0; i < 48; i++) x[i] = r[E_T[i] - 1];
        x = x ^ k;
        for (int b = 0; b < 8; b++) begin
            six = x[b*6 +: 6];
            s[b*4 +: 4] = 4'(SBOX_T[{b[2:0], six[0], six[5], six[1:4]}]);
        end
        for (int i = 0; i < 32; i++) p[i] = s[P_T[i] - 1];
        return p;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            roundCnt_q <= '0;
            left_q     <= '0;
            right_q    <= '0;
            decrypt_q  <= 1'b0;
            dataOut_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            roundCnt_q <= roundCnt_d;
            left_q     <= left_d;
            right_q    <= right_d;
            decrypt_q  <= decrypt_d;
            dataOut_q  <= dataOut_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        roundCnt_d = roundCnt_q;
        left_d     = left_q;
        right_d    = right_q;
        decrypt_d  = decrypt_q;
        dataOut_d  = dataOut_q;
        done_d     = 1'b0;
        ipOut      = initPerm(data_in_i);
        fOut       = feistel(right_q, subkey_i);
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    left_d     = ipOut[0:31];
                    right_d    = ipOut[32:63];
                    decrypt_d  = decrypt_i;
                    roundCnt_d = '0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                left_d     = right_q;
                right_d    = left_q ^ fOut;
                roundCnt_d = roundCnt_q + 4'd1;
                // Last round: output the swapped preoutput {R16, L16} straight from this round's results.
                if (roundCnt_q == 4'd15) begin
                    dataOut_d = finalPerm({left_q ^ fOut, right_q});
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o     = (state_q == RUN);
    assign key_idx_o  = !busy_o ? 4'd0 : (decrypt_q ? ~roundCnt_q : roundCnt_q);
    assign done_o     = done_q;
    assign data_out_o = dataOut_q;

endmodule

// File: tb/tb_des_iter_core.sv
// Bench for des_iter_core: a whole-cipher DES model plus an op timeline, checked every cycle,
// with FIPS vectors pinning the model and directed reset / back-to-back / ignored-start cases.
module tb_des_iter_core;

    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};
    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};
    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    localparam int SBOX [8][64] = '{
        '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7, 0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
          4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0, 15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
        '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10, 3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
          0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15, 13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
        '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
          13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7, 1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
        '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15, 13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
          10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4, 3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
        '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9, 14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
          4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14, 11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
        '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11, 10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
          9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6, 4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
        '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1, 13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
          1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2, 6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
        '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7, 1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
          7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8, 2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}};

    localparam logic [0:63] FIPS_KEY = 64'h133457799BBCDFF1;
    localparam logic [0:63] FIPS_PT  = 64'h0123456789ABCDEF;
    localparam logic [0:63] FIPS_CT  = 64'h85E813540F0AB405;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start_i = 1'b0;
    logic        decrypt_i = 1'b0;
    logic [0:63] data_in_i = '0;
    logic [0:47] subkey_i;
    logic [3:0]  key_idx_o;
    logic        busy_o;
    logic        done_o;
    logic [0:63] data_out_o;

    logic [0:47] ks [16];
    logic [0:63] curKey = '0;
    int          vectors = 0;
    int          miscompares = 0;
    int          cycleNo = 0;
    int          startCycle = 0;

    // Model timeline: opAge is rounds elapsed since the accepted start, -1 when idle.
    int          opAge = -1;
    logic        expDec = 1'b0;
    logic        expDone = 1'b0;
    logic [0:63] expOut = '0;
    logic [0:63] pendingOut = '0;

    des_iter_core dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .decrypt_i  (decrypt_i),
        .data_in_i  (data_in_i),
        .subkey_i   (subkey_i),
        .key_idx_o  (key_idx_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .data_out_o (data_out_o)
    );

    always #5 clk = ~clk;
    assign subkey_i = ks[key_idx_o];

    function automatic logic [0:47] subkeyOf(input logic [0:63] key, input int n);
        logic [0:55] cd;
        logic [0:27] c, d;
        logic [0:47] k;
        int sh = 0;
        for (int i = 0; i < 56; i++) cd[i] = key[PC1_T[i] - 1];
        for (int i = 0; i <= n; i++) sh += SHIFTS[i];
        c = cd[0:27];
        d = cd[28:55];
        c = (c << sh) | (c >> (28 - sh));
        d = (d << sh) | (d >> (28 - sh));
        cd = {c, d};
        for (int i = 0; i < 48; i++) k[i] = cd[PC2_T[i] - 1];
        return k;
    endfunction

    function automatic logic [0:31] fModel(input logic [0:31] r, input logic [0:47] k);
        logic [0:47] x;
        logic [0:31] s, p;
        int row, col, v;
        for (int i = 0; i < 48; i++) x[i] = r[E_T[i] - 1] ^ k[i];
        for (int b = 0; b < 8; b++) begin
            row = 2 * x[6*b] + x[6*b+5];
            col = 8 * x[6*b+1] + 4 * x[6*b+2] + 2 * x[6*b+3] + x[6*b+4];
            v = SBOX[b][16*row + col];
            for (int j = 0; j < 4; j++) s[4*b + j] = v[3-j];
        end
        for (int i = 0; i < 32; i++) p[i] = s[P_T[i] - 1];
        return p;
    endfunction

    function automatic logic [0:63] desModel(input logic [0:63] key, input logic [0:63] blk, input logic dec);
        logic [0:63] x, y;
        logic [0:31] l, r, t;
        for (int i = 0; i < 64; i++) x[i] = blk[IP_T[i] - 1];
        l = x[0:31];
        r = x[32:63];
        for (int n = 0; n < 16; n++) begin
            t = r;
            r = l ^ fModel(r, subkeyOf(key, dec ? 15 - n : n));
            l = t;
        end
        x = {r, l};
        for (int i = 0; i < 64; i++) y[i] = x[FP_T[i] - 1];
        return y;
    endfunction

    function automatic logic [63:0] expKeyIdx();
        if (opAge < 0) return 64'd0;
        return expDec ? 64'(15 - opAge) : 64'(opAge);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic loadKey(input logic [0:63] key);
        curKey = key;
        for (int n = 0; n < 16; n++) ks[n] = subkeyOf(key, n);
    endtask

    // Returns #1 after the start edge; data_in/decrypt are then scrambled to expose any re-sampling.
    task automatic applyStimulus(input logic [0:63] blk, input logic dec, input bit immediate);
        if (!immediate) @(negedge clk);
        data_in_i = blk;
        decrypt_i = dec;
        start_i   = 1'b1;
        @(posedge clk);
        #1;
        start_i    = 1'b0;
        data_in_i  = {$urandom, $urandom};
        decrypt_i  = ~dec;
        startCycle = cycleNo;
    endtask

    task automatic waitDone(output int latency);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done_o) break;
        end
        checkOutput("done seen", 64'(done_o), 64'd1);
        latency = cycleNo - startCycle;
    endtask

    always @(posedge clk) cycleNo <= cycleNo + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opAge   <= -1;
            expOut  <= '0;
            expDone <= 1'b0;
        end else begin
            expDone <= 1'b0;
            if (opAge >= 0) begin
                if (opAge == 15) begin
                    expOut  <= pendingOut;
                    expDone <= 1'b1;
                    opAge   <= -1;
                end else begin
                    opAge <= opAge + 1;
                end
            end else if (start_i) begin
                pendingOut <= desModel(curKey, data_in_i, decrypt_i);
                expDec     <= decrypt_i;
                opAge      <= 0;
            end
        end
    end

    always @(negedge clk) begin
        checkOutput("busy", 64'(busy_o), 64'(opAge >= 0));
        checkOutput("done", 64'(done_o), 64'(expDone));
        checkOutput("key_idx", 64'(key_idx_o), expKeyIdx());
        checkOutput("data_out", data_out_o, expOut);
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [0:63] blk;
        logic        dec;
        int          lat;
        int          donePulses;

        loadKey(64'h0);
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        checkOutput("reset busy", 64'(busy_o), 64'd0);
        checkOutput("reset done", 64'(done_o), 64'd0);
        checkOutput("reset key_idx", 64'(key_idx_o), 64'd0);
        checkOutput("reset data_out", data_out_o, 64'd0);

        $display("[TB] FIPS encrypt");
        loadKey(FIPS_KEY);
        checkOutput("model K1", 64'(ks[0]), 64'h1B02EFFC7072);
        checkOutput("model K16", 64'(ks[15]), 64'hCB3D8B0E17F5);
        checkOutput("model encrypt", desModel(FIPS_KEY, FIPS_PT, 1'b0), FIPS_CT);
        applyStimulus(FIPS_PT, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            if (i == 0) begin
                checkOutput("first key_idx", 64'(key_idx_o), 64'd0);
                checkOutput("first subkey", 64'(subkey_i), 64'h1B02EFFC7072);
            end
            if (i == 15) begin
                checkOutput("last key_idx", 64'(key_idx_o), 64'd15);
                checkOutput("last subkey", 64'(subkey_i), 64'hCB3D8B0E17F5);
            end
            checkOutput("no early done", 64'(done_o), 64'd0);
            @(posedge clk);
            #1;
        end
        checkOutput("done at 16 clocks", 64'(done_o), 64'd1);
        checkOutput("encrypt result", data_out_o, FIPS_CT);
        @(posedge clk);
        #1;
        checkOutput("done one cycle", 64'(done_o), 64'd0);
        checkOutput("result held", data_out_o, FIPS_CT);

        $display("[TB] FIPS decrypt");
        applyStimulus(FIPS_CT, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            checkOutput("decrypt key_idx", 64'(key_idx_o), 64'(15 - i));
            @(posedge clk);
            #1;
        end
        checkOutput("decrypt done", 64'(done_o), 64'd1);
        checkOutput("decrypt result", data_out_o, FIPS_PT);

        $display("[TB] all-zero key");
        loadKey(64'h0);
        applyStimulus(64'h0, 1'b0, 1'b0);
        waitDone(lat);
        checkOutput("zero latency", 64'(lat), 64'd16);
        checkOutput("zero result", data_out_o, 64'h8CA64DE9C1B123A7);

        $display("[TB] start while busy");
        loadKey(FIPS_KEY);
        applyStimulus(FIPS_PT, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        start_i   = 1'b1;
        data_in_i = 64'hFEDCBA9876543210;
        decrypt_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        checkOutput("busy after extra start", 64'(busy_o), 64'd1);
        waitDone(lat);
        checkOutput("ignored-start latency", 64'(lat), 64'd16);
        checkOutput("ignored-start result", data_out_o, FIPS_CT);
        donePulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done_o) donePulses++;
        end
        checkOutput("single done", 64'(donePulses), 64'd0);

        $display("[TB] reset mid-operation");
        applyStimulus(FIPS_PT, 1'b0, 1'b0);
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort busy", 64'(busy_o), 64'd0);
        checkOutput("abort done", 64'(done_o), 64'd0);
        checkOutput("abort data_out", data_out_o, 64'd0);
        checkOutput("abort key_idx", 64'(key_idx_o), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        donePulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done_o) donePulses++;
        end
        checkOutput("no done after abort", 64'(donePulses), 64'd0);
        applyStimulus(FIPS_PT, 1'b0, 1'b0);
        waitDone(lat);
        checkOutput("post-abort result", data_out_o, FIPS_CT);

        $display("[TB] back-to-back");
        applyStimulus(FIPS_PT, 1'b0, 1'b0);
        waitDone(lat);
        checkOutput("b2b first result", data_out_o, FIPS_CT);
        applyStimulus(FIPS_CT, 1'b1, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        checkOutput("b2b held", data_out_o, FIPS_CT);
        waitDone(lat);
        checkOutput("b2b second latency", 64'(lat), 64'd16);
        checkOutput("b2b second result", data_out_o, FIPS_PT);

        $display("[TB] randomized operations");
        for (int n = 0; n < 16; n++) begin
            loadKey({$urandom, $urandom});
            blk = {$urandom, $urandom};
            dec = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            applyStimulus(blk, dec, 1'b0);
            if ($urandom_range(0, 1) != 0) begin
                repeat ($urandom_range(1, 10)) @(negedge clk);
                start_i   = 1'b1;
                data_in_i = {$urandom, $urandom};
                @(negedge clk);
                start_i = 1'b0;
            end
            waitDone(lat);
            checkOutput("random latency", 64'(lat), 64'd16);
            checkOutput("random result", data_out_o, desModel(curKey, blk, dec));
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
